// File: rtl/tmds_period_ctrl_pkg.sv
// Shared TMDS constants: control tokens, guard-band symbols, period encoding
// and the layout of one delay-line word.
package tmds_period_ctrl_pkg;

    typedef enum logic [1:0] {
        PERIOD_CTRL  = 2'd0,
        PERIOD_PRE   = 2'd1,
        PERIOD_GUARD = 2'd2,
        PERIOD_VIDEO = 2'd3
    } period_t;

    localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTL_TOKEN_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
    localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
    localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

    // de sits in the MSB so the delay line can tap it per stage
    typedef struct packed {
        logic       de;
        logic       hsync;
        logic       vsync;
        logic [9:0] ch2;
        logic [9:0] ch1;
        logic [9:0] ch0;
    } dly_word_t;

    function automatic logic [9:0] ctl_token(input logic [1:0] ctl);
        logic [9:0] tok;
        case (ctl)
            2'b00:   tok = CTL_TOKEN_00;
            2'b01:   tok = CTL_TOKEN_01;
            2'b10:   tok = CTL_TOKEN_10;
            default: tok = CTL_TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_period_ctrl_if.sv
// Pixel-side bundle: timing/encoder inputs and the per-slot serialiser symbols.
interface tmds_period_ctrl_if;
    logic       de_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] ch0_enc;
    logic [9:0] ch1_enc;
    logic [9:0] ch2_enc;
    logic [9:0] ch0_sym;
    logic [9:0] ch1_sym;
    logic [9:0] ch2_sym;
    logic [1:0] period;
    logic       short_blank;

    modport master (
        output de_in, hsync_in, vsync_in, ch0_enc, ch1_enc, ch2_enc,
        input  ch0_sym, ch1_sym, ch2_sym, period, short_blank
    );

    modport slave (
        input  de_in, hsync_in, vsync_in, ch0_enc, ch1_enc, ch2_enc,
        output ch0_sym, ch1_sym, ch2_sym, period, short_blank
    );
endinterface

// File: rtl/tmds_period_ctrl_sym_delay_line.sv
// Synchronously cleared shift register; also exposes one chosen bit of every
// stage so the caller can see whether anything of interest is in flight.
module sym_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAP   = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [DEPTH-1:0] taps
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        taps = '0;
        for (int i = 0; i < DEPTH; i++) taps[i] = stage[i][TAP];
    end

    assign data_out = stage[DEPTH-1];

endmodule

// File: rtl/tmds_period_ctrl.sv
// Per-pixel-clock TMDS slot scheduler: delays video by PRE_LEN+GB_LEN so the
// preamble and guard band can be inserted ahead of each active line.
module tmds_period_ctrl
    import tmds_period_ctrl_pkg::*;
#(
    parameter int PRE_LEN   = 8,
    parameter int GB_LEN    = 2,
    parameter int HDMI_MODE = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    tmds_period_ctrl_if.slave  bus
);

    localparam int DLY     = PRE_LEN + GB_LEN;
    localparam int CNT_MAX = (PRE_LEN > GB_LEN) ? PRE_LEN : GB_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit HDMI_ON = (HDMI_MODE != 0);

    logic [$bits(dly_word_t)-1:0] word_in;
    logic [$bits(dly_word_t)-1:0] word_raw;
    dly_word_t                    word_out;
    logic [DLY-1:0]               de_taps;

    assign word_in  = {bus.de_in, bus.hsync_in, bus.vsync_in,
                       bus.ch2_enc, bus.ch1_enc, bus.ch0_enc};
    assign word_out = dly_word_t'(word_raw);

    sym_delay_line #(
        .WIDTH ($bits(dly_word_t)),
        .DEPTH (DLY)
    ) u_delay (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .data_in  (word_in),
        .data_out (word_raw),
        .taps     (de_taps)
    );

    period_t          state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             de_prev;
    logic             short_blank_q, short_blank_set;
    logic [9:0]       sym0_q, sym1_q, sym2_q;
    logic [9:0]       sym0_n, sym1_n, sym2_n;
    logic             line_start, line_empty;

    assign line_start = bus.de_in & ~de_prev;
    assign line_empty = ~|de_taps;

    // state holds the period of the slot currently on the outputs, so the
    // output registers are loaded from next_state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= PERIOD_CTRL;
            cnt           <= '0;
            de_prev       <= 1'b1;
            short_blank_q <= 1'b0;
            sym0_q        <= CTL_TOKEN_00;
            sym1_q        <= CTL_TOKEN_00;
            sym2_q        <= CTL_TOKEN_00;
        end else begin
            state         <= next_state;
            cnt           <= cnt_next;
            de_prev       <= bus.de_in;
            short_blank_q <= short_blank_q | short_blank_set;
            sym0_q        <= sym0_n;
            sym1_q        <= sym1_n;
            sym2_q        <= sym2_n;
        end
    end

    // de_prev resets high so a line already running at reset release is not
    // mistaken for a fresh line and given a partial preamble
    always_comb begin
        next_state      = state;
        cnt_next        = cnt;
        short_blank_set = HDMI_ON && line_start &&
                          (!line_empty || state != PERIOD_CTRL);
        case (state)
            PERIOD_CTRL: begin
                if (word_out.de) begin
                    next_state = PERIOD_VIDEO;
                end else if (HDMI_ON && line_start && line_empty) begin
                    next_state = PERIOD_PRE;
                    cnt_next   = CNT_W'(PRE_LEN - 1);
                end
            end
            PERIOD_PRE: begin
                if (cnt == '0) begin
                    next_state = PERIOD_GUARD;
                    cnt_next   = CNT_W'(GB_LEN - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            PERIOD_GUARD: begin
                if (word_out.de) next_state = PERIOD_VIDEO;
                else if (cnt != '0) cnt_next = cnt - CNT_W'(1);
            end
            default: begin
                if (!word_out.de) next_state = PERIOD_CTRL;
            end
        endcase
    end

    always_comb begin
        sym0_n = ctl_token({word_out.vsync, word_out.hsync});
        sym1_n = CTL_TOKEN_00;
        sym2_n = CTL_TOKEN_00;
        case (next_state)
            PERIOD_PRE: begin
                sym1_n = CTL_TOKEN_01;
            end
            PERIOD_GUARD: begin
                sym0_n = GUARD_CH0;
                sym1_n = GUARD_CH1;
                sym2_n = GUARD_CH2;
            end
            PERIOD_VIDEO: begin
                sym0_n = word_out.ch0;
                sym1_n = word_out.ch1;
                sym2_n = word_out.ch2;
            end
            default: ;
        endcase
    end

    assign bus.ch0_sym     = sym0_q;
    assign bus.ch1_sym     = sym1_q;
    assign bus.ch2_sym     = sym2_q;
    assign bus.period      = state;
    assign bus.short_blank = short_blank_q;

endmodule

// File: tb/tb_tmds_period_ctrl.sv
// Directed bench: an HDMI-mode and a DVI-mode instance see identical stimulus.
module tb_tmds_period_ctrl;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] GB0   = 10'b1011001100;
    localparam logic [9:0] GB1   = 10'b0100110011;
    localparam logic [9:0] GB2   = 10'b1011001100;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_bad    = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    tmds_period_ctrl_if hdmi_bus ();
    tmds_period_ctrl_if dvi_bus ();

    assign dvi_bus.de_in    = hdmi_bus.de_in;
    assign dvi_bus.hsync_in = hdmi_bus.hsync_in;
    assign dvi_bus.vsync_in = hdmi_bus.vsync_in;
    assign dvi_bus.ch0_enc  = hdmi_bus.ch0_enc;
    assign dvi_bus.ch1_enc  = hdmi_bus.ch1_enc;
    assign dvi_bus.ch2_enc  = hdmi_bus.ch2_enc;

    tmds_period_ctrl #(.PRE_LEN(8), .GB_LEN(2), .HDMI_MODE(1)) u_hdmi (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (hdmi_bus.slave)
    );

    tmds_period_ctrl #(.PRE_LEN(8), .GB_LEN(2), .HDMI_MODE(0)) u_dvi (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (dvi_bus.slave)
    );

    function automatic logic [9:0] enc_val(input int ch, input int n);
        return 10'((n * 37 + ch * 211 + 5) % 1024);
    endfunction

    function automatic bit in_line(input int k, input int l1, input int gap, input int l2);
        return (k >= 0 && k < l1) || (k >= l1 + gap && k < l1 + gap + l2);
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs);
        hdmi_bus.de_in    = de;
        hdmi_bus.hsync_in = hs;
        hdmi_bus.vsync_in = vs;
        hdmi_bus.ch0_enc  = enc_val(0, cyc);
        hdmi_bus.ch1_enc  = enc_val(1, cyc);
        hdmi_bus.ch2_enc  = enc_val(2, cyc);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic check_all(input string tag, input logic [9:0] s0, input logic [9:0] s1,
                             input logic [9:0] s2, input logic [1:0] per, input logic sb);
        check({tag, " hdmi ch0"}, hdmi_bus.ch0_sym, s0);
        check({tag, " hdmi ch1"}, hdmi_bus.ch1_sym, s1);
        check({tag, " hdmi ch2"}, hdmi_bus.ch2_sym, s2);
        check({tag, " hdmi period"}, 10'(hdmi_bus.period), 10'(per));
        check({tag, " hdmi short_blank"}, 10'(hdmi_bus.short_blank), 10'(sb));
    endtask

    // One or two lines starting at k=0 after long blanking; the first line gets
    // PRE in k=1..8 and GUARD in k=9..10, video appears 11 slots after its input
    task automatic run_seq(input int l1, input int gap, input int l2, input int span,
                           input int sb_from);
        int t0;
        t0 = cyc;
        for (int k = 0; k < span; k++) begin
            string tag;
            bit    vid;
            logic  sb;
            tag = $sformatf("k%0d", k);
            vid = (k >= 11) && in_line(k - 11, l1, gap, l2);
            sb  = (k >= sb_from);
            drive(in_line(k, l1, gap, l2), 1'b0, 1'b0);
            if (vid)
                check_all(tag, enc_val(0, t0 + k - 11), enc_val(1, t0 + k - 11),
                          enc_val(2, t0 + k - 11), 2'd3, sb);
            else if (k >= 1 && k <= 8)
                check_all(tag, TOK00, TOK01, TOK00, 2'd1, sb);
            else if (k >= 9 && k <= 10)
                check_all(tag, GB0, GB1, GB2, 2'd2, sb);
            else
                check_all(tag, TOK00, TOK00, TOK00, 2'd0, sb);
            check({tag, " dvi ch0"}, dvi_bus.ch0_sym, vid ? enc_val(0, t0 + k - 11) : TOK00);
            check({tag, " dvi ch1"}, dvi_bus.ch1_sym, vid ? enc_val(1, t0 + k - 11) : TOK00);
            check({tag, " dvi period"}, 10'(dvi_bus.period), vid ? 10'd3 : 10'd0);
            check({tag, " dvi short_blank"}, 10'(dvi_bus.short_blank), 10'd0);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            drive(1'b0, 1'b0, 1'b0);
        end
        check_all("reset", TOK00, TOK00, TOK00, 2'd0, 1'b0);
        check("reset dvi ch0", dvi_bus.ch0_sym, TOK00);
        rst = 1'b0;
        blank(40);

        $display("[TB] single 16-pixel line");
        run_seq(16, 100, 0, 32, 1000);

        $display("[TB] vsync-only control period");
        blank(20);
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, 1'b0, k == 0);
            check($sformatf("vsync k%0d hdmi ch0", k), hdmi_bus.ch0_sym, (k == 11) ? TOK10 : TOK00);
            check($sformatf("vsync k%0d dvi ch0", k), dvi_bus.ch0_sym, (k == 11) ? TOK10 : TOK00);
            check($sformatf("vsync k%0d hdmi ch1", k), hdmi_bus.ch1_sym, TOK00);
            step();
        end
        blank(30);

        $display("[TB] two lines with 4-clock blanking");
        run_seq(16, 4, 16, 52, 21);
        blank(40);
        check("short_blank sticky", 10'(hdmi_bus.short_blank), 10'd1);

        $display("[TB] reset during preamble");
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (k >= 1 && k <= 4)
                check($sformatf("rstpre k%0d period", k), 10'(hdmi_bus.period), 10'd1);
            if (k == 5) begin
                rst = 1'b0;
                check_all("after reset", TOK00, TOK00, TOK00, 2'd0, 1'b0);
            end
            if (k == 4) rst = 1'b1;
            step();
        end
        blank(40);

        $display("[TB] line after reset release");
        run_seq(16, 100, 0, 30, 1000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
